// File: rtl/ram_ctrl.sv
// ram_ctrl: byte-addressable single-port RAM with request/ready handshake,
// per-byte write enables, read wait states and a post-reset array clear.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module ram_ctrl #(
    parameter int ADDR_SIZE = `ADDR_SIZE,
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int READ_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   wr,
    input  logic [ADDR_SIZE-1:0]   addr,
    input  logic [WORD_SIZE/8-1:0] be,
    input  logic [WORD_SIZE-1:0]   wdata,
    output logic                   ready,
    output logic                   rvalid,
    output logic [WORD_SIZE-1:0]   rdata,
    output logic                   busy
);

    localparam int NB    = WORD_SIZE / 8;
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_CHUNK = ADDR_SIZE'(DEPTH - NB);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
    logic [ADDR_SIZE-1:0]   raddr_q, raddr_d;
    logic [2:0]             wait_q, wait_d;
    logic                   rvalid_q, rvalid_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;

    logic [7:0]             mem_q [DEPTH];

    logic [NB-1:0]          we;
    logic [ADDR_SIZE-1:0]   wa [NB];
    logic [7:0]             wd [NB];
    logic [ADDR_SIZE-1:0]   rd_base;
    logic [WORD_SIZE-1:0]   rd_word;

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_INIT);
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

    // A zero-wait read samples the array on the accept edge itself,
    // so the read base comes straight from the request bus in IDLE.
    assign rd_base = (state_q == S_IDLE) ? addr : raddr_q;

    // Gather the NB bytes starting at rd_base, wrapping modulo DEPTH.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NB; k++) begin
            rd_word[8*k +: 8] = mem_q[rd_base + ADDR_SIZE'(k)];
        end
    end

    // Next-state, byte-lane write strobes and read response capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        raddr_d = raddr_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        we      = '0;
        for (int k = 0; k < NB; k++) begin
            wa[k] = addr + ADDR_SIZE'(k);
            wd[k] = wdata[8*k +: 8];
        end

        unique case (state_q)
            S_INIT: begin
                we = '1;
                for (int k = 0; k < NB; k++) begin
                    wa[k] = ptr_q + ADDR_SIZE'(k);
                    wd[k] = 8'h00;
                end
                ptr_d = ptr_q + ADDR_SIZE'(NB);
                if (ptr_q == LAST_CHUNK) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req) begin
                    if (wr) begin
                        we = be;
                    end else begin
                        raddr_d = addr;
                        wait_d  = 3'(READ_WAIT);
                        state_d = (READ_WAIT == 0) ? S_RESP : S_RWAIT;
                    end
                end
            end
            S_RWAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Reset leaves the array untouched; the clear happens in INIT.
        if (!rst) begin
            we = '0;
        end

        if (state_d == S_RESP && state_q != S_RESP) begin
            rdata_d = rd_word;
        end
        rvalid_d = (state_d == S_RESP);
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_INIT;
            ptr_q    <= '0;
            raddr_q  <= '0;
            wait_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            raddr_q  <= raddr_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Byte array: one write port per lane, strobes already reset-gated.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (we[k]) begin
                mem_q[wa[k]] <= wd[k];
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed checks of clear, read/write, byte enables,
// wrap, reset during a read, back-pressure and read wait states.
`timescale 1ns/1ps

module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [7:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        req_m, req_0, req_3;

    logic        rdy_m, rv_m, busy_m;
    logic [15:0] rd_m;
    logic        rdy_0, rv_0, busy_0;
    logic [15:0] rd_0;
    logic        rdy_3, rv_3, busy_3;
    logic [15:0] rd_3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_ctrl u_dut (
        .clk(clk), .rst(rst), .req(req_m), .wr(wr), .addr(addr),
        .be(be), .wdata(wdata), .ready(rdy_m), .rvalid(rv_m),
        .rdata(rd_m), .busy(busy_m)
    );

    ram_ctrl #(.READ_WAIT(0)) u_rw0 (
        .clk(clk), .rst(rst), .req(req_0), .wr(wr), .addr(addr),
        .be(be), .wdata(wdata), .ready(rdy_0), .rvalid(rv_0),
        .rdata(rd_0), .busy(busy_0)
    );

    ram_ctrl #(.READ_WAIT(3)) u_rw3 (
        .clk(clk), .rst(rst), .req(req_3), .wr(wr), .addr(addr),
        .be(be), .wdata(wdata), .ready(rdy_3), .rvalid(rv_3),
        .rdata(rd_3), .busy(busy_3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input logic v);
        case (d)
            1: req_0 = v;
            2: req_3 = v;
            default: req_m = v;
        endcase
    endtask

    function automatic logic get_rv(input int d);
        case (d)
            1: return rv_0;
            2: return rv_3;
            default: return rv_m;
        endcase
    endfunction

    function automatic logic [15:0] get_rd(input int d);
        case (d)
            1: return rd_0;
            2: return rd_3;
            default: return rd_m;
        endcase
    endfunction

    task automatic do_write(input int d, input logic [7:0] a,
                            input logic [15:0] v, input logic [1:0] b);
        addr  = a;
        wdata = v;
        be    = b;
        wr    = 1'b1;
        set_req(d, 1'b1);
        tick;
        set_req(d, 1'b0);
        wr = 1'b0;
    endtask

    // Returns cycles from accept to rvalid (1 = first cycle after accept).
    task automatic do_read(input int d, input logic [7:0] a,
                           output int n, output logic [15:0] data);
        addr = a;
        wr   = 1'b0;
        set_req(d, 1'b1);
        tick;
        set_req(d, 1'b0);
        n = 1;
        while (get_rv(d) !== 1'b1 && n <= 20) begin
            tick;
            n++;
        end
        data = get_rd(d);
        tick;
    endtask

    // Counts the 127 clear cycles that must show busy; optional write poke.
    task automatic wait_clear(input bit poke, output int bad);
        bad = 0;
        for (int i = 1; i <= 127; i++) begin
            tick;
            if (rdy_m !== 1'b0 || busy_m !== 1'b1) bad++;
            if (poke && i == 100) begin
                addr  = 8'h02;
                wdata = 16'hFFFF;
                be    = 2'b11;
                wr    = 1'b1;
                req_m = 1'b1;
            end
            if (poke && i == 101) begin
                req_m = 1'b0;
                wr    = 1'b0;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        int bad;
        int n;
        logic [15:0] d;
        rst = 1'b0;
        tick;
        tick;
        checks++;
        if (rv_m !== 1'b0)
            $display("FAIL reset_rvalid got=%b exp=0", rv_m);
        checks++;
        if (rd_m !== 16'h0000)
            $display("FAIL reset_rdata got=%h exp=0000", rd_m);
        checks++;
        if (rdy_m !== 1'b0)
            $display("FAIL reset_ready got=%b exp=0", rdy_m);
        checks++;
        if (busy_m !== 1'b1)
            $display("FAIL reset_busy got=%b exp=1", busy_m);
        if (rv_m !== 1'b0) failures++;
        if (rd_m !== 16'h0000) failures++;
        if (rdy_m !== 1'b0) failures++;
        if (busy_m !== 1'b1) failures++;
        rst = 1'b1;
        wait_clear(1'b0, bad);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL clear_busy_cycles bad=%0d exp=0", bad);
        end
        checks++;
        if (rdy_m !== 1'b1 || busy_m !== 1'b0) begin
            failures++;
            $display("FAIL clear_done ready=%b busy=%b exp=1/0",
                     rdy_m, busy_m);
        end
        do_read(0, 8'h00, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL clr_rd_00 lat=%0d data=%h exp=2/0000", n, d);
        end
        do_read(0, 8'h7F, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL clr_rd_7f lat=%0d data=%h exp=2/0000", n, d);
        end
        do_read(0, 8'hFE, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL clr_rd_fe lat=%0d data=%h exp=2/0000", n, d);
        end
    endtask

    task automatic test_write_read;
        int n;
        logic [15:0] d;
        do_write(0, 8'h10, 16'hBEEF, 2'b11);
        do_read(0, 8'h10, n, d);
        checks++;
        if (n !== 2 || d !== 16'hBEEF) begin
            failures++;
            $display("FAIL wr_rd_10 lat=%0d data=%h exp=2/beef", n, d);
        end
        do_read(0, 8'h11, n, d);
        checks++;
        if (n !== 2 || d !== 16'h00BE) begin
            failures++;
            $display("FAIL rd_11 lat=%0d data=%h exp=2/00be", n, d);
        end
    endtask

    task automatic test_byte_enable;
        int n;
        logic [15:0] d;
        do_write(0, 8'h20, 16'hBEEF, 2'b11);
        do_write(0, 8'h20, 16'h1234, 2'b01);
        do_read(0, 8'h20, n, d);
        checks++;
        if (n !== 2 || d !== 16'hBE34) begin
            failures++;
            $display("FAIL be_lo lat=%0d data=%h exp=2/be34", n, d);
        end
        do_write(0, 8'h20, 16'h5600, 2'b10);
        do_write(0, 8'h20, 16'hFFFF, 2'b00);
        do_read(0, 8'h20, n, d);
        checks++;
        if (n !== 2 || d !== 16'h5634) begin
            failures++;
            $display("FAIL be_hi lat=%0d data=%h exp=2/5634", n, d);
        end
    endtask

    task automatic test_wrap;
        int n;
        logic [15:0] d;
        do_write(0, 8'hFF, 16'hA55A, 2'b11);
        do_read(0, 8'hFF, n, d);
        checks++;
        if (n !== 2 || d !== 16'hA55A) begin
            failures++;
            $display("FAIL wrap_ff lat=%0d data=%h exp=2/a55a", n, d);
        end
        do_read(0, 8'h00, n, d);
        checks++;
        if (n !== 2 || d !== 16'h00A5) begin
            failures++;
            $display("FAIL wrap_00 lat=%0d data=%h exp=2/00a5", n, d);
        end
    endtask

    task automatic test_reset_mid_read;
        int n;
        int bad;
        int seen;
        logic [15:0] d;
        do_write(0, 8'h10, 16'hBEEF, 2'b11);
        addr  = 8'h10;
        wr    = 1'b0;
        req_m = 1'b1;
        tick;
        req_m = 1'b0;
        rst   = 1'b0;
        seen  = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rv_m !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_rst_rvalid pulses=%0d exp=0", seen);
        end
        rst = 1'b1;
        wait_clear(1'b1, bad);
        checks++;
        if (bad !== 0 || rdy_m !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_clear bad=%0d ready=%b exp=0/1",
                     bad, rdy_m);
        end
        do_read(0, 8'h10, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL mid_rst_rd_10 lat=%0d data=%h exp=2/0000", n, d);
        end
        do_read(0, 8'h02, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL init_wr_ignored lat=%0d data=%h exp=2/0000", n, d);
        end
    endtask

    task automatic test_rwait_backpressure;
        int n;
        logic [15:0] d;
        addr  = 8'h40;
        wr    = 1'b0;
        req_m = 1'b1;
        tick;
        checks++;
        if (rdy_m !== 1'b0) begin
            failures++;
            $display("FAIL rwait_ready got=%b exp=0", rdy_m);
        end
        wdata = 16'h1111;
        be    = 2'b11;
        wr    = 1'b1;
        tick;
        req_m = 1'b0;
        wr    = 1'b0;
        checks++;
        if (rv_m !== 1'b1 || rd_m !== 16'h0000) begin
            failures++;
            $display("FAIL rwait_resp rvalid=%b data=%h exp=1/0000",
                     rv_m, rd_m);
        end
        tick;
        do_read(0, 8'h40, n, d);
        checks++;
        if (n !== 2 || d !== 16'h0000) begin
            failures++;
            $display("FAIL rwait_wr_ignored lat=%0d data=%h exp=2/0000", n, d);
        end
    endtask

    task automatic test_wait_sweep;
        int n;
        logic [15:0] d;
        do_write(1, 8'h50, 16'hC0DE, 2'b11);
        do_read(1, 8'h50, n, d);
        checks++;
        if (n !== 1 || d !== 16'hC0DE) begin
            failures++;
            $display("FAIL rw0_read lat=%0d data=%h exp=1/c0de", n, d);
        end
        do_write(2, 8'h60, 16'hF00D, 2'b11);
        do_read(2, 8'h60, n, d);
        checks++;
        if (n !== 4 || d !== 16'hF00D) begin
            failures++;
            $display("FAIL rw3_read lat=%0d data=%h exp=4/f00d", n, d);
        end
        do_read(2, 8'h61, n, d);
        checks++;
        if (n !== 4 || d !== 16'h00F0) begin
            failures++;
            $display("FAIL rw3_read_61 lat=%0d data=%h exp=4/00f0", n, d);
        end
    endtask

    initial begin
        rst   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        req_m = 1'b0;
        req_0 = 1'b0;
        req_3 = 1'b0;
        test_reset;
        test_write_read;
        test_byte_enable;
        test_wrap;
        test_reset_mid_read;
        test_rwait_backpressure;
        test_wait_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
